// File: rtl/hdp_port_arbiter.sv
// hdp_port_arbiter: round-robin arbiter sharing a half-duplex pad bundle with direction turnaround.
// Define HDP_BUS_PARK_EN to keep the pads driven with the last write beat while idle.
module hdp_port_arbiter #(
  parameter int N = 2,
  parameter int W = 8,
  parameter int LW = 4,
  parameter int TA = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_dir,
  input  logic [N*LW-1:0] req_len,
  input  logic [N*W-1:0]  wdata,
  input  logic [W-1:0]    pad_i,
  output logic [W-1:0]    pad_o,
  output logic            pad_oe,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    wready,
  output logic [N-1:0]    rvalid,
  output logic [W-1:0]    rdata,
  output logic [N-1:0]    done,
  output logic            busy
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] TURN = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [3:0] TLOAD = 4'(TA > 0 ? TA - 1 : 0);
`ifdef HDP_BUS_PARK_EN
  localparam logic PARK = 1'b1;
`else
  localparam logic PARK = 1'b0;
`endif
  logic [1:0] state;
  logic bus_dir, dir, go_turn;
  logic [PW-1:0] rr_ptr, win, pick, idx;
  logic [LW-1:0] len, cnt;
  logic [3:0] tcnt;
  logic [N-1:0] oh;
  // later iterations overwrite, so the lowest offset from rr_ptr wins
  always_comb begin
    pick = rr_ptr;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % N);
      if (req[idx]) pick = idx;
    end
  end
  assign go_turn = (req_dir[pick] != bus_dir) && (TA > 0);
  assign oh = N'(1) << win;
  assign busy = state != IDLE;
  assign gnt = busy ? oh : '0;
  assign wready = (state == XFER && dir) ? oh : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bus_dir <= 1'b0;
      rr_ptr <= '0;
      win <= '0;
      dir <= 1'b0;
      len <= '0;
      cnt <= '0;
      tcnt <= '0;
      pad_o <= '0;
      pad_oe <= 1'b0;
      rvalid <= '0;
      rdata <= '0;
      done <= '0;
    end else begin
      done <= '0;
      rvalid <= '0;
      case (state)
        IDLE: begin
          pad_oe <= PARK && pad_oe && !(|req && go_turn);
          if (|req) begin
            win <= pick;
            dir <= req_dir[pick];
            len <= req_len[int'(pick)*LW +: LW];
            cnt <= '0;
            rr_ptr <= PW'((int'(pick) + 1) % N);
            tcnt <= TLOAD;
            state <= go_turn ? TURN : XFER;
            if (!go_turn) bus_dir <= req_dir[pick];
          end
        end
        TURN: begin
          pad_oe <= 1'b0;
          tcnt <= tcnt - 4'd1;
          if (tcnt == 4'd0) begin
            state <= XFER;
            bus_dir <= dir;
          end
        end
        XFER: begin
          pad_oe <= dir;
          if (dir) pad_o <= wdata[int'(win)*W +: W];
          else begin
            rdata <= pad_i;
            rvalid <= oh;
          end
          cnt <= cnt + LW'(1);
          if (cnt == len) begin
            state <= IDLE;
            done <= oh;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hdp_port_arbiter.sv
// tb_hdp_port_arbiter: directed scenarios plus randomized traffic checked against a burst-schedule model.
module tb_hdp_port_arbiter;
  localparam int N = 2, W = 8, LW = 4, TA = 2, D = 8192, INF = 1 << 30;
`ifdef HDP_BUS_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0, req_dir = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N*W-1:0] wdata = '0;
  logic [W-1:0] pad_i = '0;
  logic [W-1:0] pad_o, rdata;
  logic pad_oe, busy;
  logic [N-1:0] gnt, wready, rvalid, done;
  int checks = 0, errors = 0, cyc = 0;

  hdp_port_arbiter #(.N(N), .W(W), .LW(LW), .TA(TA)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir), .req_len(req_len),
    .wdata(wdata), .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe), .gnt(gnt),
    .wready(wready), .rvalid(rvalid), .rdata(rdata), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Model: each granted burst is expanded into a per-cycle schedule of expected outputs.
  logic [N-1:0] g_a[D], wr_a[D], rv_a[D], dn_a[D];
  bit oe_a[D], rs_a[D];
  int who_a[D];
  logic [W-1:0] pd_a[D], rd_a[D];
  int free_at, rr, pk_from, mc;
  bit mbus, eo;
  logic [W-1:0] last_pad;

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      g_a[i] = '0; wr_a[i] = '0; rv_a[i] = '0; dn_a[i] = '0;
      oe_a[i] = 0; rs_a[i] = 0; who_a[i] = 0; pd_a[i] = '0; rd_a[i] = '0;
    end
    free_at = 0; rr = 0; mbus = 0; pk_from = INF; last_pad = '0;
  endtask

  task automatic arbitrate(input int c);
    int w, t, l, s;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req[(rr + k) % N]) w = (rr + k) % N;
    l = int'(req_len[w*LW +: LW]);
    t = (req_dir[w] != mbus && TA > 0) ? TA : 0;
    for (int i = 1; i <= t + l + 1; i++) g_a[c+i] = N'(1) << w;
    for (int b = 0; b <= l; b++) begin
      s = c + t + 1 + b;
      who_a[s] = w;
      if (req_dir[w]) begin wr_a[s] = N'(1) << w; oe_a[s+1] = 1; end
      else begin rs_a[s] = 1; rv_a[s+1] = N'(1) << w; end
    end
    dn_a[c+t+l+2] = N'(1) << w;
    free_at = c + t + l + 2;
    mbus = req_dir[w];
    rr = (w + 1) % N;
    if (!req_dir[w]) pk_from = INF;
    else if (pk_from == INF) pk_from = c + t + 2;
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    else begin
      mc = cyc;
      chk("gnt", 32'(gnt), 32'(g_a[mc]));
      chk("busy", 32'(busy), 32'(|g_a[mc]));
      chk("wready", 32'(wready), 32'(wr_a[mc]));
      chk("rvalid", 32'(rvalid), 32'(rv_a[mc]));
      chk("done", 32'(done), 32'(dn_a[mc]));
      eo = oe_a[mc] || (PARK && mc >= pk_from);
      chk("pad_oe", 32'(pad_oe), 32'(eo));
      if (oe_a[mc]) last_pad = pd_a[mc];
      if (eo) chk("pad_o", 32'(pad_o), 32'(last_pad));
      if (rv_a[mc] != 0) chk("rdata", 32'(rdata), 32'(rd_a[mc]));
      if (wr_a[mc] != 0) pd_a[mc+1] = wdata[who_a[mc]*W +: W];
      if (rs_a[mc]) rd_a[mc+1] = pad_i;
      if (mc >= free_at && |req) arbitrate(mc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    tick(2);
    rst = 0;
    tick(1);
    req = 2'b01; req_dir = 2'b01; req_len = 8'h03; wdata = 16'h0011;
    tick(1); req = '0;
    tick(3); #2 rst = 1; #1;
    chk("rst_gnt", 32'(gnt), 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_wready", 32'(wready), 0); chk("rst_pad_oe", 32'(pad_oe), 0);
    chk("rst_pad_o", 32'(pad_o), 0); chk("rst_done", 32'(done), 0);
    chk("rst_rvalid", 32'(rvalid), 0); chk("rst_rdata", 32'(rdata), 0);
    tick(1); rst = 0;
    tick(1); req = 2'b01; req_dir = 2'b01; req_len = 8'h02; wdata = 16'h00A5;
    tick(1); req = '0; #5 chk("wr_gnt", 32'(gnt), 1); chk("wr_turn_oe", 32'(pad_oe), 0);
    tick(1); #5 chk("wr_turn_wready", 32'(wready), 0); chk("wr_turn_oe2", 32'(pad_oe), 0);
    tick(1); #5 chk("wr_wready", 32'(wready), 1);
    tick(1); wdata = 16'h003C; #5 chk("wr_oe", 32'(pad_oe), 1); chk("wr_beat0", 32'(pad_o), 32'hA5);
    tick(1); wdata = 16'h000F; #5 chk("wr_beat1", 32'(pad_o), 32'h3C);
    tick(1); req = 2'b01; req_dir = 2'b01; req_len = 8'h00; wdata = 16'h0077;
    #5 chk("wr_beat2", 32'(pad_o), 32'h0F); chk("wr_done", 32'(done), 1); chk("wr_idle", 32'(busy), 0);
    tick(1); req = '0; #5 chk("b2b_gnt", 32'(gnt), 1); chk("b2b_wready", 32'(wready), 1);
    tick(1); req = 2'b01; req_dir = 2'b00; req_len = 8'h01; pad_i = 8'h11;
    #5 chk("b2b_beat", 32'(pad_o), 32'h77); chk("b2b_done", 32'(done), 1);
    tick(1); req = '0; #5 chk("rd_turn_oe", 32'(pad_oe), 0); chk("rd_gnt", 32'(gnt), 1);
    tick(1); #5 chk("rd_turn_rvalid", 32'(rvalid), 0);
    tick(1);
    tick(1); pad_i = 8'h22; #5 chk("rd_rvalid0", 32'(rvalid), 1); chk("rd_data0", 32'(rdata), 32'h11);
    tick(1); req = 2'b10; req_dir = 2'b00; req_len = 8'h00;
    #5 chk("rd_rvalid1", 32'(rvalid), 1); chk("rd_data1", 32'(rdata), 32'h22); chk("rd_done", 32'(done), 1);
    tick(1); req = '0; #5 chk("r1_gnt", 32'(gnt), 2);
    tick(1); req = 2'b11; #5 chk("r1_done", 32'(done), 2);
    tick(1); #5 chk("rr_gnt0", 32'(gnt), 1);
    tick(1); #5 chk("rr_gap", 32'(gnt), 0);
    tick(1); #5 chk("rr_gnt1", 32'(gnt), 2);
    tick(2); #5 chk("rr_gnt2", 32'(gnt), 1);
    tick(2); req = '0; #5 chk("rr_gnt3", 32'(gnt), 2);
    tick(2); req = 2'b01; req_dir = 2'b01; req_len = 8'h00; wdata = 16'h005A;
    tick(1); req = '0;
    tick(3); #5 chk("pk_oe", 32'(pad_oe), 1); chk("pk_beat", 32'(pad_o), 32'h5A);
    for (int i = 0; i < 5; i++) begin tick(1); #5 chk("pk_idle_oe", 32'(pad_oe), 32'(PARK)); end
    tick(1); req = 2'b01; req_dir = 2'b00;
    tick(1); req = '0; #5 chk("pk_turn_oe", 32'(pad_oe), 0);
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if ($urandom_range(0, 499) == 0) begin rst = 1; tick(1); rst = 0; end
      req = N'($urandom_range(0, 3));
      req_dir = N'($urandom_range(0, 3));
      for (int j = 0; j < N; j++)
        req_len[j*LW +: LW] = LW'($urandom_range(0, 9) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3));
      wdata = (N*W)'($urandom);
      pad_i = W'($urandom);
    end
    req = '0;
    tick(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
